// File: rtl/byte_arb_pkg.sv
// Shared types for the byte store arbiter: FSM states, grant encoding,
// strobe counter width.
package byte_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/byte_store_arbiter_rr.sv
// Two-input round-robin arbiter; the last-grant register lives in the
// parent so this block stays purely combinational.
module rr_arbiter_2
    import byte_arb_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  grant_t last_grant,
    output logic   grant_valid,
    output grant_t grant_sel
);

    always_comb begin
        grant_valid = req_a | req_b;
        grant_sel   = GRANT_A;
        unique case (1'b1)
            (req_a && req_b):
                grant_sel = (last_grant == GRANT_A) ? GRANT_B : GRANT_A;
            (!req_a && req_b):
                grant_sel = GRANT_B;
            default:
                grant_sel = GRANT_A;
        endcase
    end

endmodule

// File: rtl/byte_store_arbiter.sv
// Shares a bank of latch byte memories between two writers with
// setup/strobe/hold sequencing. Optional readback check: BYTE_STORE_VERIFY_EN.
module byte_store_arbiter
    import byte_arb_pkg::*;
#(
    parameter int NUM_BYTES     = 4,
    parameter int ADDR_W        = 2,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_a,
    input  logic [ADDR_W-1:0]    addr_a,
    input  logic [7:0]           data_a,
    output logic                 ack_a,
    input  logic                 req_b,
    input  logic [ADDR_W-1:0]    addr_b,
    input  logic [7:0]           data_b,
    output logic                 ack_b,
    output logic [7:0]           wdata,
    output logic [NUM_BYTES-1:0] store,
    output logic                 busy,
    output logic                 addr_err
`ifdef BYTE_STORE_VERIFY_EN
    ,
    input  logic [NUM_BYTES*8-1:0] rdata,
    output logic                   verify_err
`endif
);

    state_t              state;
    grant_t              last_grant;
    grant_t              gnt;
    grant_t              grant_sel;
    logic                grant_valid;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    cnt;
    logic                addr_ok;
    logic [NUM_BYTES-1:0] sel_oh;

    rr_arbiter_2 u_rr (
        .req_a       (req_a),
        .req_b       (req_b),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    assign addr_ok = (int'(addr_q) < NUM_BYTES);
    assign sel_oh  = NUM_BYTES'(1) << addr_q;

    // wdata doubles as the captured data register; it only moves at grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_B;
            gnt        <= GRANT_A;
            addr_q     <= '0;
            cnt        <= '0;
            wdata      <= '0;
            store      <= '0;
            busy       <= 1'b0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            addr_err   <= 1'b0;
`ifdef BYTE_STORE_VERIFY_EN
            verify_err <= 1'b0;
`endif
        end else begin
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            addr_err <= 1'b0;
`ifdef BYTE_STORE_VERIFY_EN
            verify_err <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gnt        <= grant_sel;
                        last_grant <= grant_sel;
                        addr_q     <= (grant_sel == GRANT_A) ? addr_a : addr_b;
                        wdata      <= (grant_sel == GRANT_A) ? data_a : data_b;
                        busy       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    cnt      <= CNT_W'(STROBE_CYCLES - 1);
                    store    <= addr_ok ? sel_oh : '0;
                    addr_err <= !addr_ok;
                    state    <= STROBE;
                end
                STROBE: begin
                    if (cnt == '0) begin
                        store <= '0;
                        ack_a <= (gnt == GRANT_A);
                        ack_b <= (gnt == GRANT_B);
`ifdef BYTE_STORE_VERIFY_EN
                        if (addr_ok && (rdata[8*int'(addr_q) +: 8] != wdata))
                            verify_err <= 1'b1;
`endif
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_store_arbiter.sv
// Directed bench: vector table on the default build, plus hand sequences
// for ties, back-to-back, bad address, long strobe and mid-op reset.
module tb_byte_store_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a, req_b;
    logic [1:0] addr_a, addr_b;
    logic [7:0] data_a, data_b;

    logic       ack_a0, ack_b0, busy0, aerr0;
    logic [7:0] wdata0;
    logic [3:0] store0;
    logic       ack_a1, ack_b1, busy1, aerr1;
    logic [7:0] wdata1;
    logic [2:0] store1;
    logic       ack_a2, ack_b2, busy2, aerr2;
    logic [7:0] wdata2;
    logic [3:0] store2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

`ifdef BYTE_STORE_VERIFY_EN
    logic [7:0]  flip = 8'h00;
    logic [31:0] rdata0;
    logic [23:0] rdata1 = '0;
    logic [31:0] rdata2 = '0;
    logic        verr0, verr1, verr2;
    assign rdata0 = {4{wdata0 ^ flip}};
`endif

    byte_store_arbiter u0 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a0),
        .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b0),
        .wdata(wdata0), .store(store0), .busy(busy0), .addr_err(aerr0)
`ifdef BYTE_STORE_VERIFY_EN
        , .rdata(rdata0), .verify_err(verr0)
`endif
    );

    byte_store_arbiter #(.NUM_BYTES(3)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a1),
        .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b1),
        .wdata(wdata1), .store(store1), .busy(busy1), .addr_err(aerr1)
`ifdef BYTE_STORE_VERIFY_EN
        , .rdata(rdata1), .verify_err(verr1)
`endif
    );

    byte_store_arbiter #(.STROBE_CYCLES(3)) u2 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a2),
        .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b2),
        .wdata(wdata2), .store(store2), .busy(busy2), .addr_err(aerr2)
`ifdef BYTE_STORE_VERIFY_EN
        , .rdata(rdata2), .verify_err(verr2)
`endif
    );

    typedef struct {
        logic       ra;
        logic [1:0] aa;
        logic [7:0] da;
        logic       rb;
        logic [1:0] ab;
        logic [7:0] db;
        logic       win_a;
        logic [3:0] st;
        logic [7:0] wd;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // store must stay one-hot and never coincide with a wdata change
    logic [7:0] prev_wd = 8'h00;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("mon_onehot", {31'd0, $onehot0(store0)}, 32'd1);
            if (store0 != 4'd0)
                chk("mon_wd_stable", {24'd0, wdata0}, {24'd0, prev_wd});
        end
        prev_wd = wdata0;
    end

    initial begin
        int acks;
        req_a  = 1'b0;
        req_b  = 1'b0;
        addr_a = '0;
        addr_b = '0;
        data_a = '0;
        data_b = '0;

        tbl[0] = '{1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b1, 4'b0100, 8'hA5};
        tbl[1] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h5A, 1'b0, 4'b0001, 8'h5A};
        tbl[2] = '{1'b1, 2'd3, 8'hFF, 1'b1, 2'd1, 8'h3C, 1'b1, 4'b1000, 8'hFF};
        tbl[3] = '{1'b1, 2'd3, 8'hFF, 1'b1, 2'd1, 8'h3C, 1'b0, 4'b0010, 8'h3C};
        tbl[4] = '{1'b1, 2'd1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 4'b0010, 8'h00};

        tick();
        tick();
        chk("rst_store", {28'd0, store0}, 32'd0);
        chk("rst_wdata", {24'd0, wdata0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_acks", {30'd0, ack_a0, ack_b0}, 32'd0);
        chk("rst_aerr", {31'd0, aerr0}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            req_a  = tbl[i].ra;
            addr_a = tbl[i].aa;
            data_a = tbl[i].da;
            req_b  = tbl[i].rb;
            addr_b = tbl[i].ab;
            data_b = tbl[i].db;
            tick();
            chk("vec_setup_busy", {31'd0, busy0}, 32'd1);
            chk("vec_setup_store", {28'd0, store0}, 32'd0);
            chk("vec_setup_wdata", {24'd0, wdata0}, {24'd0, tbl[i].wd});
            tick();
            chk("vec_strobe", {28'd0, store0}, {28'd0, tbl[i].st});
            tick();
            chk("vec_hold_acks", {30'd0, ack_a0, ack_b0},
                {30'd0, tbl[i].win_a, !tbl[i].win_a});
            chk("vec_hold_store", {28'd0, store0}, 32'd0);
            req_a = 1'b0;
            req_b = 1'b0;
            tick();
            chk("vec_idle_busy", {31'd0, busy0}, 32'd0);
            chk("vec_idle_wdata", {24'd0, wdata0}, {24'd0, tbl[i].wd});
        end

        // tie from reset, then a second tie after B has been served
        do_reset();
        req_a = 1'b1; addr_a = 2'd2; data_a = 8'hA5;
        req_b = 1'b1; addr_b = 2'd1; data_b = 8'h3C;
        tick(); tick(); tick();
        chk("tie_ack_a", {30'd0, ack_a0, ack_b0}, 32'd2);
        req_a = 1'b0;
        tick(); tick(); tick();
        chk("tie_store_b", {28'd0, store0}, 32'b0010);
        tick();
        chk("tie_ack_b", {30'd0, ack_a0, ack_b0}, 32'd1);
        req_a = 1'b1; addr_a = 2'd0; data_a = 8'h11;
        tick();
        chk("tie2_idle", {31'd0, busy0}, 32'd0);
        tick();
        chk("tie2_wdata", {24'd0, wdata0}, 32'h11);
        tick();
        chk("tie2_store", {28'd0, store0}, 32'b0001);
        tick();
        chk("tie2_ack", {30'd0, ack_a0, ack_b0}, 32'd2);
        req_a = 1'b0;
        req_b = 1'b0;
        tick();

        // back-to-back on B
        do_reset();
        req_b = 1'b1; addr_b = 2'd0; data_b = 8'h11;
        tick(); tick(); tick();
        chk("b2b_ack1", {31'd0, ack_b0}, 32'd1);
        chk("b2b_gap0", {28'd0, store0}, 32'd0);
        addr_b = 2'd3; data_b = 8'h0F;
        tick();
        chk("b2b_gap1", {28'd0, store0}, 32'd0);
        tick();
        chk("b2b_gap2", {28'd0, store0}, 32'd0);
        chk("b2b_wdata", {24'd0, wdata0}, 32'h0F);
        tick();
        chk("b2b_store2", {28'd0, store0}, 32'b1000);
        tick();
        chk("b2b_ack2", {31'd0, ack_b0}, 32'd1);
        req_b = 1'b0;
        tick();

        // out-of-range slot on the 3-byte instance
        do_reset();
        req_a = 1'b1; addr_a = 2'd3; data_a = 8'h77;
        tick();
        chk("bad_setup_aerr", {31'd0, aerr1}, 32'd0);
        chk("bad_setup_busy", {31'd0, busy1}, 32'd1);
        tick();
        chk("bad_strobe_aerr", {31'd0, aerr1}, 32'd1);
        chk("bad_strobe_store", {29'd0, store1}, 32'd0);
        tick();
        chk("bad_hold_ack", {31'd0, ack_a1}, 32'd1);
        chk("bad_hold_aerr", {31'd0, aerr1}, 32'd0);
        chk("bad_hold_store", {29'd0, store1}, 32'd0);
        req_a = 1'b0;
        tick();

        // three-cycle strobe instance
        do_reset();
        req_a = 1'b1; addr_a = 2'd1; data_a = 8'hC3;
        tick();
        chk("s3_setup_store", {28'd0, store2}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("s3_strobe", {28'd0, store2}, 32'b0010);
            chk("s3_no_ack", {31'd0, ack_a2}, 32'd0);
        end
        tick();
        chk("s3_ack", {31'd0, ack_a2}, 32'd1);
        chk("s3_hold_store", {28'd0, store2}, 32'd0);
        req_a = 1'b0;
        tick();

        req_a = 1'b1; addr_a = 2'd2; data_a = 8'h5A;
        tick();
        tick();
        chk("s3rst_strobe1", {28'd0, store2}, 32'b0100);
        req_a = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("s3rst_store_drop", {28'd0, store2}, 32'd0);
        chk("s3rst_busy_drop", {31'd0, busy2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ack_a2) acks++;
        end
        chk("s3rst_no_ack", acks, 32'd0);
        req_a = 1'b1; addr_a = 2'd0; data_a = 8'hE7;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("s3post_strobe", {28'd0, store2}, 32'b0001);
        end
        tick();
        chk("s3post_ack", {31'd0, ack_a2}, 32'd1);
        chk("s3post_wdata", {24'd0, wdata2}, 32'hE7);
        req_a = 1'b0;
        tick();

`ifdef BYTE_STORE_VERIFY_EN
        do_reset();
        flip  = 8'h01;
        req_a = 1'b1; addr_a = 2'd2; data_a = 8'hA5;
        tick(); tick(); tick();
        chk("ver_bad_ack", {31'd0, ack_a0}, 32'd1);
        chk("ver_bad_err", {31'd0, verr0}, 32'd1);
        req_a = 1'b0;
        tick();
        chk("ver_err_clear", {31'd0, verr0}, 32'd0);
        flip  = 8'h00;
        req_a = 1'b1;
        tick(); tick(); tick();
        chk("ver_ok_ack", {31'd0, ack_a0}, 32'd1);
        chk("ver_ok_err", {31'd0, verr0}, 32'd0);
        req_a = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
